// File: rtl/fpu_alpha_recursion_pkg.sv
// Shared constants and types for the alpha forward-recursion unit of the
// 8-state LTE turbo constituent decoder.
package fpu_alpha_recursion_pkg;

    localparam int ALPHA_BA_W  = 10;
    localparam int ALPHA_LSP_W = 6;

    // Bit k set: butterfly k uses gm_a, else gm_b.
    localparam logic [3:0] BFLY_SEL_GM_A = 4'b1001;

    localparam logic signed [ALPHA_BA_W-1:0] METRIC_IMPOSSIBLE =
        ALPHA_BA_W'(-(2 ** (ALPHA_BA_W - 2)));

    typedef enum logic [1:0] {
        INIT_KNOWN       = 2'd0,
        INIT_UNIFORM     = 2'd1,
        INIT_CARRY       = 2'd2,
        INIT_UNIFORM_ALT = 2'd3
    } init_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } alpha_state_e;

endpackage

// File: rtl/fpu_alpha_acs.sv
// Four add-compare-select butterflies of the 8-state trellis, normalised to
// the pre-step state-0 metric and saturated back to BA_W bits.
module fpu_alpha_acs
    import fpu_alpha_recursion_pkg::*;
#(
    parameter int BA_W = ALPHA_BA_W,
    parameter int GM_W = ALPHA_LSP_W + 2
) (
    input  logic [8*BA_W-1:0] old_m,
    input  logic [GM_W-1:0]   gm_a,
    input  logic [GM_W-1:0]   gm_b,
    output logic [8*BA_W-1:0] new_m
);

    localparam int EW = BA_W + 2;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (BA_W - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (BA_W - 1)));

    function automatic logic signed [EW-1:0] sx_m(input logic [BA_W-1:0] m);
        return {{2{m[BA_W-1]}}, m};
    endfunction

    function automatic logic signed [EW-1:0] sx_g(input logic [GM_W-1:0] g);
        return {{(EW-GM_W){g[GM_W-1]}}, g};
    endfunction

    function automatic logic [BA_W-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[BA_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[BA_W-1:0];
        return v[BA_W-1:0];
    endfunction

    logic signed [EW-1:0] norm;

    assign norm = sx_m(old_m[0 +: BA_W]);

    for (genvar k = 0; k < 4; k++) begin : g_bfly
        logic signed [EW-1:0] g;
        logic signed [EW-1:0] m0;
        logic signed [EW-1:0] m1;
        logic signed [EW-1:0] up0;
        logic signed [EW-1:0] dn0;
        logic signed [EW-1:0] up1;
        logic signed [EW-1:0] dn1;
        logic signed [EW-1:0] new_lo;
        logic signed [EW-1:0] new_hi;

        assign g   = BFLY_SEL_GM_A[k] ? sx_g(gm_a) : sx_g(gm_b);
        assign m0  = sx_m(old_m[(2*k)*BA_W +: BA_W]);
        assign m1  = sx_m(old_m[(2*k+1)*BA_W +: BA_W]);
        assign up0 = m0 + g;
        assign dn0 = m0 - g;
        assign up1 = m1 + g;
        assign dn1 = m1 - g;

        assign new_lo = ((up0 > dn1) ? up0 : dn1) - norm;
        assign new_hi = ((dn0 > up1) ? dn0 : up1) - norm;

        assign new_m[k*BA_W +: BA_W]     = sat(new_lo);
        assign new_m[(k+4)*BA_W +: BA_W] = sat(new_hi);
    end

endmodule

// File: rtl/fpu_alpha_recursion.sv
// Alpha forward-recursion unit: window FSM, step counter and metric
// registers; writes pre-step metrics of every accepted step to alpha RAM.
module fpu_alpha_recursion
    import fpu_alpha_recursion_pkg::*;
#(
    parameter int BA_W    = ALPHA_BA_W,
    parameter int LSP_W   = ALPHA_LSP_W,
    parameter int WIN_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          init_mode,
    input  logic                bm_valid,
    output logic                bm_ready,
    input  logic [LSP_W+1:0]    gm_a,
    input  logic [LSP_W+1:0]    gm_b,
    output logic                alpha_we,
    output logic [ADDR_W-1:0]   alpha_waddr,
    output logic [8*BA_W-1:0]   alpha_wdata,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(WIN_LEN - 1);
    localparam logic [BA_W-1:0]   IMPOSSIBLE = BA_W'(METRIC_IMPOSSIBLE);

    alpha_state_e      state_q, state_d;
    init_mode_e        mode_q, mode_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [8*BA_W-1:0] metric_q, metric_d;
    logic [8*BA_W-1:0] acs_m;
    logic              accept;

    fpu_alpha_acs #(
        .BA_W (BA_W),
        .GM_W (LSP_W + 2)
    ) u_acs (
        .old_m (metric_q),
        .gm_a  (gm_a),
        .gm_b  (gm_b),
        .new_m (acs_m)
    );

    assign accept = (state_q == ST_RUN) && bm_valid;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        step_d   = step_q;
        metric_d = metric_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                    mode_d  = init_mode_e'(init_mode);
                end
            end
            ST_INIT: begin
                state_d = ST_RUN;
                // Carry mode keeps the final metrics of the previous window.
                unique case (mode_q)
                    INIT_KNOWN: metric_d = {{7{IMPOSSIBLE}}, {BA_W{1'b0}}};
                    INIT_CARRY: metric_d = metric_q;
                    default:    metric_d = '0;
                endcase
            end
            ST_RUN: begin
                if (accept) begin
                    metric_d = acs_m;
                    if (step_q == LAST_STEP) begin
                        step_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= INIT_KNOWN;
            step_q   <= '0;
            metric_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            step_q   <= step_d;
            metric_q <= metric_d;
        end
    end

    assign bm_ready    = (state_q == ST_RUN);
    assign alpha_we    = accept;
    assign alpha_waddr = step_q;
    assign alpha_wdata = metric_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule
